// File: rtl/mdu_pkg.sv
// Shared types and defaults for the multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between a requester (master) and the multiply/divide unit (slave).
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mult, start_div, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mdu_div_core.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_divisor};
    if (!w_diff[WIDTH]) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and, when MDU_DIV_EN is defined, signed
// restoring divide; one step per clock, WIDTH steps per operation.
//
// state | meaning
// IDLE  | waiting for a start request
// MULT  | one Booth step per cycle
// DIV   | one restoring-divide step per cycle
// DONE  | hi/lo just updated, done pulse for this cycle
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic  i_clock,
  input logic  i_reset_n,
  mdu_if.slave bus
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  op_t              w_op;
  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    r_cnt;
  // One guard bit: the Booth partial sum can reach +2^(WIDTH-1) when M is the minimum value.
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_q_1;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_q_1_nxt;

  always_comb begin
    w_accept = 1'b0;
    w_op     = OP_MULT;
    if (r_state == ST_IDLE || r_state == ST_DONE) begin
      if (bus.start_mult) begin
        w_accept = 1'b1;
      end
`ifdef MDU_DIV_EN
      else if (bus.start_div) begin
        w_accept = 1'b1;
        w_op     = OP_DIV;
      end
`endif
    end
  end

  assign w_last = (r_cnt == LAST_STEP);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept && w_op == OP_DIV) begin
          w_state_nxt = ST_DIV;
        end else if (w_accept) begin
          w_state_nxt = ST_MULT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MULT, ST_DIV: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_m_ext = {r_m[WIDTH-1], r_m};
    case ({r_q[0], r_q_1})
      2'b01:   w_booth_sum = r_acc + w_m_ext;
      2'b10:   w_booth_sum = r_acc - w_m_ext;
      default: w_booth_sum = r_acc;
    endcase
    {w_acc_nxt, w_q_nxt, w_q_1_nxt} = {w_booth_sum[WIDTH], w_booth_sum, r_q};
  end

`ifdef MDU_DIV_EN
  logic             r_a_neg;
  logic             r_b_neg;
  logic             r_b_zero;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_quo_fix;

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .i_rem     (r_acc[WIDTH-1:0]),
    .i_quo     (r_q),
    .i_divisor (r_m),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  always_comb begin
    w_a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
    w_b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
    w_quo_fix = (r_a_neg ^ r_b_neg) ? -w_quo_nxt : w_quo_nxt;
    w_rem_fix = r_a_neg ? -w_rem_nxt : w_rem_nxt;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_a_neg    <= 1'b0;
      r_b_neg    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_a_raw    <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_a_neg    <= bus.a[WIDTH-1];
      r_b_neg    <= bus.b[WIDTH-1];
      r_b_zero   <= (bus.b == '0);
      r_a_raw    <= bus.a;
      r_div_zero <= 1'b0;
    end else if (r_state == ST_DIV && w_last) begin
      r_div_zero <= r_b_zero;
    end
  end

  assign bus.div_zero = (r_state == ST_DONE) && r_div_zero;
`else
  logic w_unused_div;
  assign w_unused_div = bus.start_div;
  assign bus.div_zero = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_q_1 <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_q_1 <= 1'b0;
      if (w_op == OP_MULT) begin
        r_m <= bus.a;
        r_q <= bus.b;
      end
`ifdef MDU_DIV_EN
      else begin
        r_m <= w_b_mag;
        r_q <= w_a_mag;
      end
`endif
    end else if (r_state == ST_MULT) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_q_1 <= w_q_1_nxt;
      if (w_last) begin
        r_hi <= w_acc_nxt[WIDTH-1:0];
        r_lo <= w_q_nxt;
      end
    end
`ifdef MDU_DIV_EN
    else if (r_state == ST_DIV) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= {1'b0, w_rem_nxt};
      r_q   <= w_quo_nxt;
      if (w_last) begin
        // Zero divisor: the iteration result is meaningless, report the dividend instead.
        if (r_b_zero) begin
          r_hi <= r_a_raw;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end
      end
    end
`endif
  end

  assign bus.busy = (r_state == ST_MULT) || (r_state == ST_DIV);
  assign bus.done = (r_state == ST_DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit (32-bit and 8-bit instances).
module tb_mult_div_unit;

  typedef struct {
    logic        sm;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus32 ();
  mdu_if #(.WIDTH(8))  bus8 ();

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus32)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus8)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sm, input logic sd, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] hi,
                              input logic [31:0] lo, input logic dz);
    vec_t v;
    v.sm = sm; v.sd = sd; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    return v;
  endfunction

  task automatic run32(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    bus32.start_mult = v.sm;
    bus32.start_div  = v.sd;
    bus32.a          = v.a;
    bus32.b          = v.b;
    @(negedge clk);
    bus32.start_mult = 1'b0;
    bus32.start_div  = 1'b0;
    bus32.a          = $urandom;
    bus32.b          = $urandom;
    check($sformatf("v%0d_busy_after_accept", idx), 64'(bus32.busy), 64'd1);
    lat = 0;
    while (!bus32.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'd32);
    check($sformatf("v%0d_hi", idx), 64'(bus32.hi), 64'(v.hi));
    check($sformatf("v%0d_lo", idx), 64'(bus32.lo), 64'(v.lo));
    check($sformatf("v%0d_div_zero", idx), 64'(bus32.div_zero), 64'(v.dz));
    check($sformatf("v%0d_busy_in_done", idx), 64'(bus32.busy), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse_end", idx), 64'(bus32.done), 64'd0);
    check($sformatf("v%0d_hold", idx), {bus32.hi, bus32.lo}, {v.hi, v.lo});
  endtask

  initial begin
    int lat;
    int dones;
    int bad;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    vecs.push_back(mk(1, 0, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 0));
    vecs.push_back(mk(1, 0, -32'sd3,      32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0));
    vecs.push_back(mk(1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0));
    vecs.push_back(mk(1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0));
    vecs.push_back(mk(1, 0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 0));
    vecs.push_back(mk(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0));
    vecs.push_back(mk(1, 1, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 0));
`ifdef MDU_DIV_EN
    vecs.push_back(mk(0, 1, -32'sd7,      32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0));
    vecs.push_back(mk(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0));
    vecs.push_back(mk(0, 1, 32'd9,        32'd0,        32'h00000009, 32'hFFFFFFFF, 1));
    vecs.push_back(mk(0, 1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 0));
    vecs.push_back(mk(0, 1, 32'd7,        -32'sd2,      32'h00000001, 32'hFFFFFFFD, 0));
    vecs.push_back(mk(0, 1, -32'sd100,    -32'sd7,      32'hFFFFFFFE, 32'h0000000E, 0));
    vecs.push_back(mk(0, 1, -32'sd5,      32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1));
`endif

    bus32.start_mult = 1'b0; bus32.start_div = 1'b0; bus32.a = '0; bus32.b = '0;
    bus8.start_mult  = 1'b0; bus8.start_div  = 1'b0; bus8.a  = '0; bus8.b  = '0;

    repeat (3) @(negedge clk);
    check("reset_state32", {bus32.busy, bus32.done, bus32.div_zero, bus32.hi, bus32.lo}, '0);
    check("reset_state8", {bus8.busy, bus8.done, bus8.div_zero, bus8.hi, bus8.lo}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run32(vecs[i], i);
    end

    // A start arriving mid-operation must be ignored.
    @(negedge clk);
    bus32.start_mult = 1'b1; bus32.a = 32'd7; bus32.b = 32'd6;
    @(negedge clk);
    bus32.start_mult = 1'b0; bus32.a = 32'd1; bus32.b = 32'd1;
    dones = 0; lat = 0; hi_q = '1; lo_q = '1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      bus32.start_mult = (k == 5);
      if (bus32.done) begin
        dones++;
        if (dones == 1) begin
          lat = k; hi_q = bus32.hi; lo_q = bus32.lo;
        end
      end
    end
    bus32.start_mult = 1'b0;
    check("midop_start_single_done", 64'(dones), 64'd1);
    check("midop_start_latency", 64'(lat), 64'd32);
    check("midop_start_result", {hi_q, lo_q}, {32'h0, 32'h2A});

    // Reset in the middle of an operation aborts it immediately.
    @(negedge clk);
`ifdef MDU_DIV_EN
    bus32.start_div = 1'b1;
`else
    bus32.start_mult = 1'b1;
`endif
    bus32.a = 32'd100; bus32.b = 32'd7;
    @(negedge clk);
    bus32.start_mult = 1'b0; bus32.start_div = 1'b0;
    repeat (9) @(negedge clk);
    check("midop_busy_before_reset", 64'(bus32.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_midop_busy", 64'(bus32.busy), 64'd0);
    check("reset_midop_done", 64'(bus32.done), 64'd0);
    check("reset_midop_hilo", {bus32.hi, bus32.lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done || bus32.busy) bad++;
    end
    check("reset_midop_no_done", 64'(bad), 64'd0);
    run32(mk(1, 0, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0), 100);

    // 8-bit instance: extreme multiply.
    @(negedge clk);
    bus8.start_mult = 1'b1; bus8.a = 8'h80; bus8.b = 8'hFF;
    @(negedge clk);
    bus8.start_mult = 1'b0; bus8.a = 8'h5A; bus8.b = 8'hA5;
    check("w8_busy_after_accept", 64'(bus8.busy), 64'd1);
    lat = 0;
    while (!bus8.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("w8_latency", 64'(lat), 64'd8);
    check("w8_result", {bus8.hi, bus8.lo}, 64'h0080);

`ifndef MDU_DIV_EN
    // Without the divider, divide requests do nothing.
    @(negedge clk);
    bus32.start_div = 1'b1; bus32.a = 32'd9; bus32.b = 32'd3;
    bus8.start_div  = 1'b1; bus8.a  = 8'd9;  bus8.b  = 8'd3;
    @(negedge clk);
    bus32.start_div = 1'b0; bus8.start_div = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.busy || bus32.done || bus8.busy || bus8.done) bad++;
    end
    check("div_ignored", 64'(bad), 64'd0);
    check("div_ignored_hilo8", {bus8.hi, bus8.lo}, 64'h0080);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width (legal: even values, 8 to 64).
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start_mult  input  1  request a signed multiply of a by b.
REQ-005 Port: start_div  input  1  request a signed divide of a by b.
REQ-006 Port: a  input  WIDTH  operand A (multiplicand or dividend), from register A.
REQ-007 Port: b  input  WIDTH  operand B (multiplier or divisor), from register B.
REQ-008 Port: busy  output  1  high while an operation is iterating.
REQ-009 Port: done  output  1  one-cycle pulse when hi/lo are updated.
REQ-010 Port: div_zero  output  1  divide-by-zero flag, valid in the done cycle only.
REQ-011 Port: hi  output  WIDTH  HI result: product upper half, or remainder.
REQ-012 Port: lo  output  WIDTH  LO result: product lower half, or quotient.

Function
REQ-013 FSM states: IDLE, MULT, DIV, DONE.
REQ-014 A start is accepted only in IDLE or DONE; a start in MULT or DIV is ignored.
REQ-015 If start_mult and start_div are high together, only the multiply is performed.
REQ-016 On the accepting edge, a and b are captured, the iteration counter is cleared and the FSM enters MULT or DIV; busy goes high after that edge.
REQ-017 MULT: radix-2 Booth, one step per cycle, WIDTH steps, 2*WIDTH-bit signed product.
REQ-018 DIV: restoring division on operand magnitudes, one quotient bit per cycle, WIDTH steps; signs are fixed up on completion.
REQ-019 Division semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-020 Division of MIN by -1: lo = MIN, hi = 0, no flag.
REQ-021 Divide by zero (b == 0): hi = a, lo = all ones, div_zero = 1 in the done cycle.
REQ-022 Latency: the step that completes on edge N+WIDTH (N = accept edge) enters DONE with hi/lo updated; done = 1 and busy = 0 for that cycle only.
REQ-023 DONE returns to IDLE on the next edge unless a new start is accepted.
REQ-024 hi/lo hold their last completed values until the next operation completes; intermediate values are never visible on hi/lo.
REQ-025 Operand inputs are ignored after the accept edge.

Reset
REQ-026 An asserted reset (low) forces IDLE immediately and clears busy, done, div_zero, hi, lo, the counter and internal registers.
REQ-027 Reset mid-operation aborts it with no done pulse; the first accept after reset release starts cleanly.

Configuration
REQ-028 Macro MDU_DIV_EN defined: division is implemented as specified above.
REQ-029 MDU_DIV_EN undefined: no divider logic is built; start_div is ignored; the DIV state is unreachable; div_zero is tied to 0.

Structure
REQ-030 Shared package mdu_pkg holds the FSM state enum, an op enum (OP_MULT, OP_DIV) and the WIDTH default constant.
REQ-031 One sub-module, mdu_div_core (restoring-divider step datapath), is instantiated only under MDU_DIV_EN; Booth multiply stays in the top module.

Verification
REQ-032 WIDTH=32, mult a=7, b=6 -> done 32 cycles after accept, hi=0x00000000, lo=0x0000002A.
REQ-033 Mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 Div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=0x80000000, b=-1 -> lo=0x80000000, hi=0; b=0, a=9 -> hi=9, lo=0xFFFFFFFF, div_zero=1.
REQ-035 start_mult and start_div together -> multiply result; start_mult pulsed at cycle 5 of a running op -> ignored, single done.
REQ-036 Reset asserted at cycle 10 of a div -> busy=0, hi=lo=0 immediately, no done; new mult after release -> correct result.
REQ-037 WIDTH=8 with MDU_DIV_EN undefined -> mult a=-128, b=-1 gives hi=0x00, lo=0x80 after 8 cycles; start_div -> busy stays 0, no done.
